// File: rtl/aes_decipher_round.sv
// Iterative AES inverse cipher round datapath.
// One inverse S-box word per cycle, round keys fetched by index.
module aes_decipher_round (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam logic [1:0] AES_128_BIT_KEY = 2'h0;
  localparam logic [1:0] AES_192_BIT_KEY = 2'h1;
  localparam logic [1:0] AES_256_BIT_KEY = 2'h2;
  localparam logic [3:0] AES128_ROUNDS = 4'ha;
  localparam logic [3:0] AES192_ROUNDS = 4'hc;
  localparam logic [3:0] AES256_ROUNDS = 4'he;

  typedef enum logic [2:0] {
    IDLE, INIT, SHIFT, SBOX, ARK
  } state_t;

  state_t       st;
  logic [127:0] state_reg;
  logic [3:0]   round_ctr;
  logic [1:0]   sword_ctr;
  logic [127:0] ark_t;
  logic [127:0] sub_state;
  logic [3:0]   nr;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[31-8*i -: 8];
      x2    = gm2(a[i]);
      x4    = gm2(x2);
      x8    = gm2(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return {inv_mixw(s[127:96]), inv_mixw(s[95:64]),
            inv_mixw(s[63:32]),  inv_mixw(s[31:0])};
  endfunction

  // byte (col c, row r) takes the byte from column c-r of the same row
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c + 4 - r) % 4) + r;
        o[127-8*(4*c+r) -: 8] = s[127-8*src -: 8];
      end
    end
    return o;
  endfunction

  assign round     = round_ctr;
  assign new_block = state_reg;
  assign ark_t     = state_reg ^ round_key;

  // round count for the requested key length
  always_comb begin
    nr = AES256_ROUNDS;
    case (keylen)
      AES_128_BIT_KEY: nr = AES128_ROUNDS;
      AES_192_BIT_KEY: nr = AES192_ROUNDS;
      AES_256_BIT_KEY: nr = AES256_ROUNDS;
      default:         nr = AES256_ROUNDS;
    endcase
  end

  // S-box word select and write-back of the substituted word
  always_comb begin
    sboxw     = state_reg[127:96];
    sub_state = state_reg;
    if (st == SBOX) begin
      case (sword_ctr)
        2'd0: begin
          sboxw = state_reg[127:96];
          sub_state[127:96] = new_sboxw;
        end
        2'd1: begin
          sboxw = state_reg[95:64];
          sub_state[95:64] = new_sboxw;
        end
        2'd2: begin
          sboxw = state_reg[63:32];
          sub_state[63:32] = new_sboxw;
        end
        default: begin
          sboxw = state_reg[31:0];
          sub_state[31:0] = new_sboxw;
        end
      endcase
    end
  end

  // round sequencer and state register
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      state_reg <= '0;
      ready     <= 1'b1;
      round_ctr <= 4'd0;
      sword_ctr <= 2'd0;
    end else begin
      case (st)
        IDLE: begin
          if (next && ready && keylen != 2'h3) begin
            state_reg <= block;
            round_ctr <= nr;
            ready     <= 1'b0;
            st        <= INIT;
          end
        end
        INIT: begin
          state_reg <= ark_t;
          round_ctr <= round_ctr - 4'd1;
          st        <= SHIFT;
        end
        SHIFT: begin
          state_reg <= inv_shift(state_reg);
          sword_ctr <= 2'd0;
          st        <= SBOX;
        end
        SBOX: begin
          state_reg <= sub_state;
          sword_ctr <= sword_ctr + 2'd1;
          if (sword_ctr == 2'd3) st <= ARK;
        end
        ARK: begin
          if (round_ctr != 4'd0) begin
            state_reg <= inv_mix(ark_t);
            round_ctr <= round_ctr - 4'd1;
            st        <= SHIFT;
          end else begin
            state_reg <= ark_t;
            ready     <= 1'b1;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
